crc3_sched: RTL and testbench

CRC3_SCHED -- requirements
Module: crc3_sched

---
 rtl/crc3_pkg.sv | 19 +
 rtl/crc3_serial_core.sv | 34 +++
 rtl/crc3_sched.sv | 142 ++++++++++++++
 tb/tb_crc3_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc3_pkg.sv
// Shared constants and encodings for the CRC-3 encode/check scheduler.
package crc3_pkg;

  localparam int MSG_LENGTH         = 17;  // 14 data bits + 3 check bits
  localparam int POLINOMIAL_LENGTH  = 4;   // generator width, degree 3
  localparam int CONTROL_SUM_LENGTH = 3;   // remainder / checksum width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_ENC = 1'b0,
    SRC_CHK = 1'b1
  } src_e;

endpackage

// File: rtl/crc3_serial_core.sv
// Bit-serial CRC remainder register: one message bit per enabled clock, MSB first.
module crc3_serial_core
  import crc3_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift_en,
  input  logic                          bit_in,
  input  logic [CONTROL_SUM_LENGTH-1:0] poly,
  output logic [CONTROL_SUM_LENGTH-1:0] rem
);

  logic [CONTROL_SUM_LENGTH-1:0] rem_q, rem_d;

  // Next remainder: clear on a new job, else shift in a bit and fold in the generator.
  always_comb begin
    rem_d = rem_q;
    if (clr)
      rem_d = '0;
    else if (shift_en)
      rem_d = {rem_q[CONTROL_SUM_LENGTH-2:0], bit_in}
            ^ (rem_q[CONTROL_SUM_LENGTH-1] ? poly : '0);
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign rem = rem_q;

endmodule

// File: rtl/crc3_sched.sv
// Round-robin scheduler sharing one serial CRC-3 engine between an encode
// requester and a check requester.
// Timing: the accept edge clears the remainder, the next 17 edges each shift
// one bit, and the edge carrying the 17th shift also enters DONE, so out_valid
// is seen in the 18th clock counting the accept clock. The handshake edge
// returns to IDLE, so back-to-back jobs are 19 clocks apart.
module crc3_sched #(
  parameter int MSG_LENGTH        = crc3_pkg::MSG_LENGTH,
  parameter int POLINOMIAL_LENGTH = crc3_pkg::POLINOMIAL_LENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enc_valid,
  output logic                         enc_ready,
  input  logic [MSG_LENGTH-1:0]        enc_msg,
  input  logic                         chk_valid,
  output logic                         chk_ready,
  input  logic [MSG_LENGTH-1:0]        chk_msg,
  input  logic [POLINOMIAL_LENGTH-1:0] polinom,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MSG_LENGTH-1:0]        out_msg,
  output logic                         out_src,
  output logic                         out_crc_ok,
  output logic                         busy,
  output logic [7:0]                   err_cnt
);

  import crc3_pkg::*;

  localparam int CW = $clog2(MSG_LENGTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(MSG_LENGTH - 1);
  // Encode jobs carry no checksum yet: bits below the data field are zeroed.
  localparam logic [MSG_LENGTH-1:0] ENC_MASK =
    {{(MSG_LENGTH-CONTROL_SUM_LENGTH){1'b1}}, {CONTROL_SUM_LENGTH{1'b0}}};

  state_e                        state_q;
  src_e                          src_q;
  logic                          pref_enc_q;
  logic [CW-1:0]                 cnt_q;
  logic [MSG_LENGTH-1:0]         msg_q;
  logic [CONTROL_SUM_LENGTH-1:0] poly_q;
  logic                          out_valid_q;
  logic [7:0]                    err_cnt_q;

  logic                          grant_enc, grant_chk, accept, hs;
  logic                          shift_en, bit_in, rem_zero;
  logic [CONTROL_SUM_LENGTH-1:0] rem;
  logic [CW-1:0]                 bit_idx;

  // The generator's leading coefficient is implicitly 1, so its input bit is ignored.
  logic poly_msb_unused;
  assign poly_msb_unused = polinom[POLINOMIAL_LENGTH-1];

  // Round-robin grant: a lone requester always wins, a tie goes to the preferred side.
  always_comb begin
    grant_enc = enc_valid && (!chk_valid || pref_enc_q);
    grant_chk = chk_valid && (!enc_valid || !pref_enc_q);
  end

  assign enc_ready = !rst && (state_q == ST_IDLE) && grant_enc;
  assign chk_ready = !rst && (state_q == ST_IDLE) && grant_chk;
  assign accept    = enc_ready || chk_ready;
  assign hs        = (state_q == ST_DONE) && out_ready;

  assign shift_en  = (state_q == ST_SHIFT);
  assign bit_idx   = LAST_BIT - cnt_q;
  assign bit_in    = msg_q[bit_idx];
  assign rem_zero  = (rem == '0);

  crc3_serial_core u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .poly     (poly_q),
    .rem      (rem)
  );

  // Job FSM: latch on accept, count 17 shifts, hold the result until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_ENC;
      pref_enc_q  <= 1'b1;
      cnt_q       <= '0;
      msg_q       <= '0;
      poly_q      <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            msg_q      <= grant_chk ? chk_msg : (enc_msg & ENC_MASK);
            poly_q     <= polinom[CONTROL_SUM_LENGTH-1:0];
            src_q      <= grant_chk ? SRC_CHK : SRC_ENC;
            pref_enc_q <= grant_chk;
            cnt_q      <= '0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            if (src_q == SRC_CHK && !rem_zero && err_cnt_q != 8'hFF)
              err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Result view: only driven while a result is pending, all-zero otherwise.
  always_comb begin
    out_msg    = '0;
    out_src    = 1'b0;
    out_crc_ok = 1'b0;
    if (out_valid_q) begin
      out_msg    = (src_q == SRC_CHK) ? msg_q
                 : {msg_q[MSG_LENGTH-1:CONTROL_SUM_LENGTH], rem};
      out_src    = (src_q == SRC_CHK);
      out_crc_ok = (src_q == SRC_ENC) || rem_zero;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc3_sched.sv
// Bench for crc3_sched: a job-level model (polynomial long division, grant
// rules, handshake bookkeeping) is checked against the DUT every cycle, plus
// directed literal expectations.
module tb_crc3_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_valid = 1'b0, chk_valid = 1'b0, out_ready = 1'b0;
  logic [16:0] enc_msg = '0, chk_msg = '0;
  logic [3:0]  polinom = '0;
  logic        enc_ready, chk_ready, out_valid, out_src, out_crc_ok, busy;
  logic [16:0] out_msg;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  crc3_sched dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_msg(enc_msg),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_msg(chk_msg),
    .polinom(polinom),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_src(out_src), .out_crc_ok(out_crc_ok),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message mod generator by long division; generator is {1, p}.
  function automatic logic [2:0] crc3(input logic [16:0] m, input logic [2:0] p);
    logic [16:0] w;
    logic [16:0] g;
    w = m;
    g = {13'd0, 1'b1, p};
    for (int i = 16; i >= 3; i--)
      if (w[i]) w = w ^ (g << (i - 3));
    return w[2:0];
  endfunction

  // ---------------- job-level reference model ----------------
  bit          m_idle = 1'b1, m_ov = 1'b0, m_pref_enc = 1'b1, m_src = 1'b0;
  int          m_t = 0, m_err = 0;
  logic [16:0] m_msg = '0;
  logic [2:0]  m_poly = '0;

  function automatic logic [16:0] m_out_msg();
    return m_src ? m_msg : {m_msg[16:3], crc3(m_msg, m_poly)};
  endfunction

  function automatic bit m_ok();
    return m_src ? (crc3(m_msg, m_poly) == 3'd0) : 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_ov = 1'b0; m_pref_enc = 1'b1; m_err = 0;
    end else if (m_idle) begin
      if (enc_valid || chk_valid) begin
        m_src      = chk_valid && (!enc_valid || !m_pref_enc);
        m_msg      = m_src ? chk_msg : {enc_msg[16:3], 3'b000};
        m_poly     = polinom[2:0];
        m_pref_enc = m_src;
        m_idle     = 1'b0;
        m_t        = 0;
      end
    end else if (!m_ov) begin
      m_t++;
      if (m_t == 17) m_ov = 1'b1;
    end else if (out_ready) begin
      if (m_src && !m_ok() && m_err < 255) m_err++;
      m_ov   = 1'b0;
      m_idle = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ge, gc;
    ge = !rst && m_idle && enc_valid && (!chk_valid || m_pref_enc);
    gc = !rst && m_idle && chk_valid && (!enc_valid || !m_pref_enc);
    check("enc_ready", 32'(enc_ready), 32'(ge));
    check("chk_ready", 32'(chk_ready), 32'(gc));
    check("busy", 32'(busy), 32'(!m_idle));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    if (m_ov) begin
      check("out_msg", 32'(out_msg), 32'(m_out_msg()));
      check("out_src", 32'(out_src), 32'(m_src));
      check("out_crc_ok", 32'(out_crc_ok), 32'(m_ok()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one job, wait for its accept, then count edges until out_valid.
  task automatic run_job(input bit is_chk, input logic [16:0] msg, input logic [3:0] p,
                         output int lat);
    bit got;
    polinom = p;
    if (is_chk) begin chk_valid = 1'b1; chk_msg = msg; end
    else        begin enc_valid = 1'b1; enc_msg = msg; end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = is_chk ? chk_ready : enc_ready;
    end
    if (!got) check("accept_timeout", 32'(got), 32'd1);
    tick();  // accept edge
    // Inputs after accept must not affect the job.
    enc_valid = 1'b0; chk_valid = 1'b0;
    enc_msg = 17'($urandom); chk_msg = 17'($urandom); polinom = 4'($urandom);
    lat = 0;
    while (lat < 40 && !out_valid) begin
      tick();
      lat++;
    end
  endtask

  localparam logic [16:0] ENC_IN  = 17'b11010011101100_000;
  localparam logic [16:0] CODEW   = 17'b11010011101100_100;
  localparam logic [16:0] BIT10   = 17'h00400;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit got;
    bit order [4];
    logic [16:0] cw;
    logic [13:0] data;

    // Model pin: known textbook division result.
    check("model_crc", 32'(crc3(ENC_IN, 3'b011)), 32'h4);

    // Reset with a request pending: no ready while rst is high.
    rst = 1'b1; enc_valid = 1'b1; enc_msg = ENC_IN;
    @(negedge clk);
    check("rst_enc_ready", 32'(enc_ready), 32'd0);
    tick();
    enc_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_msg", 32'(out_msg), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Encode: 17 edges after the accept edge = 18th clock counting the accept clock.
    out_ready = 1'b1;
    run_job(1'b0, ENC_IN, 4'b1011, lat);
    check("enc_latency", 32'(lat), 32'd17);
    check("enc_out_msg", 32'(out_msg), 32'(CODEW));
    check("enc_out_src", 32'(out_src), 32'd0);
    check("enc_crc_ok", 32'(out_crc_ok), 32'd1);
    tick();
    check("enc_idle_after_hs", 32'(busy), 32'd0);

    // Check good codeword, then one with bit 10 flipped.
    run_job(1'b1, CODEW, 4'b1011, lat);
    check("chk_good_ok", 32'(out_crc_ok), 32'd1);
    check("chk_good_src", 32'(out_src), 32'd1);
    check("chk_good_msg", 32'(out_msg), 32'(CODEW));
    tick();
    check("chk_good_err", 32'(err_cnt), 32'd0);
    run_job(1'b1, CODEW ^ BIT10, 4'b1011, lat);
    check("chk_bad_ok", 32'(out_crc_ok), 32'd0);
    tick();
    check("chk_bad_err", 32'(err_cnt), 32'd1);

    // Reset at shift step 8 aborts the job.
    run_job(1'b1, CODEW ^ BIT10, 4'b1011, lat);  // consumes a job to move the pointer
    tick();
    enc_valid = 1'b1; enc_msg = ENC_IN; polinom = 4'b1011;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = enc_ready;
    end
    tick();
    enc_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_msg", 32'(out_msg), 32'd0);
    check("abort_out_src", 32'(out_src), 32'd0);
    check("abort_crc_ok", 32'(out_crc_ok), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);

    // Tie for four jobs: enc, chk, enc, chk (first tie after reset goes to enc).
    enc_msg = ENC_IN; chk_msg = CODEW; polinom = 4'b1011;
    enc_valid = 1'b1; chk_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
        @(negedge clk);
        if (enc_ready || chk_ready) begin got = 1'b1; order[j] = chk_ready; end
      end
      if (!got) check("tie_timeout", 32'(got), 32'd1);
      else      check("tie_order", 32'(order[j]), 32'(j % 2));
      tick();
    end
    enc_valid = 1'b0; chk_valid = 1'b0;
    for (int n = 0; n < 40 && busy; n++) tick();
    check("tie_drained", 32'(busy), 32'd0);

    // Backpressure: result held 10 clocks, no accept until after the handshake.
    out_ready = 1'b0;
    run_job(1'b0, ENC_IN, 4'b1011, lat);
    enc_valid = 1'b1; chk_valid = 1'b1; chk_msg = CODEW;
    repeat (10) begin
      @(negedge clk);
      check("hold_msg", 32'(out_msg), 32'(CODEW));
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_readys", 32'({enc_ready, chk_ready}), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();  // handshake edge
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_chk_ready", 32'(chk_ready), 32'd1);
    check("hs_enc_ready", 32'(enc_ready), 32'd0);
    tick();  // accept edge for chk
    enc_valid = 1'b0; chk_valid = 1'b0;
    for (int n = 0; n < 40 && busy; n++) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      enc_valid = ($urandom % 3) == 0;
      chk_valid = ($urandom % 3) == 0;
      out_ready = ($urandom % 2) == 0;
      enc_msg   = 17'($urandom);
      polinom   = 4'($urandom);
      data      = 14'($urandom);
      cw        = {data, 3'b000};
      cw[2:0]   = crc3(cw, polinom[2:0]);
      if ($urandom % 2) cw = cw ^ (17'd1 << ($urandom % 17));
      chk_msg   = cw;
      rst       = ($urandom % 400) == 0;
      tick();
    end
    rst = 1'b0;

    // Saturation: stream corrupted checks until err_cnt must have hit 255.
    enc_valid = 1'b0; chk_valid = 1'b1; out_ready = 1'b1;
    polinom = 4'b1011; chk_msg = CODEW ^ BIT10;
    repeat (5500) tick();
    chk_valid = 1'b0;
    repeat (40) tick();
    check("err_saturated", 32'(err_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
